pc: RTL and testbench
=====================

PC -- requirements
Module: pc

Interface
REQ-001 Parameter WIDTH, default 7: bit width of the address path (in, out).
REQ-002 Parameter RESET_VALUE, default 0: value loaded into out on reset, WIDTH bits wide.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  WIDTH (7)  next program-counter address, computed externally.
REQ-006 out  output  WIDTH (7)  current program-counter address, driven directly from an internal register.

Function
REQ-007 The module SHALL hold a single WIDTH-bit register that drives out with no combinational path from in or rst to out.
REQ-008 On each rising clk edge with rst=0, the register SHALL load in unchanged; out reflects the new value after that edge (1-cycle latency).
REQ-009 The module SHALL NOT increment, align, mask or otherwise modify in; any WIDTH-bit value, including non-multiples of 4 and all-ones (127), SHALL pass through.
REQ-010 No wrap-around logic: out range is exactly the in range, 0 to 2^WIDTH-1.
REQ-011 Between rising edges, out SHALL remain stable regardless of changes on in or rst.
REQ-012 There is no enable or stall input: the register SHALL load on every non-reset rising edge, even when in equals out.
REQ-013 The module SHALL contain no handshake or state machine beyond the single register.

Reset
REQ-014 On a rising clk edge with rst=1, the register SHALL load RESET_VALUE (0 by default), ignoring in.
REQ-015 Reset priority: when rst=1 and in is nonzero at the same edge, reset SHALL win.
REQ-016 Asserting or deasserting rst between clock edges SHALL NOT change out until the next rising edge.
REQ-017 While rst is held high over multiple edges, out SHALL stay at RESET_VALUE on every edge.
REQ-018 On the first rising edge after rst returns to 0, the register SHALL load in normally.
REQ-019 Before the first clock edge, out is undefined; a reset edge is required before out is valid. For simulation only, the register SHALL initialise to RESET_VALUE.
REQ-020 Reset asserted mid-sequence SHALL discard the current address with no residual state.

Verification
REQ-021 Reset: rst=1, in=0, one rising edge -> out=0; release rst.
REQ-022 Increment sweep: rst=0, drive in=0,4,8,...,124, changing in once per clock period -> after each edge, out equals the in value sampled at that edge.
REQ-023 Reset held: rst=1 during the same 0..124 sweep -> out=0 on every edge.
REQ-024 Reset priority: in=124, rst=1 at the same edge -> out=0; next edge with rst=0 and in=8 -> out=8.
REQ-025 Mid-cycle stability: change in from 16 to 20 and toggle rst between edges -> out unchanged until the next rising edge.
REQ-026 Arbitrary value: rst=0, in=127 then in=3 on successive edges -> out=127 then 3, with no alignment applied.

Source files
------------

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module   : pc
// Purpose  : Program-counter register. It loads the externally computed next
//            address on every clock edge, and loads RESET_VALUE while rst is high.
// Revision : 1.0 - initial release
// ============================================================================
module pc #(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  // The address passes through untouched: there is no increment, alignment or enable.
  always_comb begin
    pc_d = in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc
// Purpose  : Scoreboard testbench for the pc register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc;

  localparam int WIDTH = 7;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] exp;
  } exp_t;

  exp_t sb_q[$];

  pc #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue the value out must hold
  // after the next rising edge.
  task automatic step(input string name, input logic r, input logic [WIDTH-1:0] v,
                      input logic [WIDTH-1:0] exp);
    exp_t e;
    @(negedge clk);
    rst = r;
    in  = v;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // The monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, out, e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_cycles;
    rst = 1'b1;
    in  = '0;

    // Reset state
    step("reset", 1'b1, 7'd0, 7'd0);

    // Increment sweep with reset released
    for (int i = 0; i < 32; i++) begin
      step("sweep", 1'b0, 7'(i * 4), 7'(i * 4));
    end

    // Same sweep with reset held high
    for (int i = 0; i < 32; i++) begin
      step("reset_held", 1'b1, 7'(i * 4), 7'd0);
    end

    // Reset priority, followed by a normal load
    step("rst_priority", 1'b1, 7'd124, 7'd0);
    step("rst_release", 1'b0, 7'd8, 7'd8);

    // Stability between edges
    step("mid_setup", 1'b0, 7'd16, 7'd16);
    @(negedge clk);
    in  = 7'd20;
    rst = 1'b1;
    #1 check("mid_in_rst_hi", out, 7'd16);
    #1 rst = 1'b0;
    #1 check("mid_rst_lo", out, 7'd16);
    begin
      exp_t e;
      e.name = "mid_next_edge";
      e.exp  = 7'd20;
      sb_q.push_back(e);
    end

    // Arbitrary values with no alignment
    step("all_ones", 1'b0, 7'd127, 7'd127);
    step("odd_value", 1'b0, 7'd3, 7'd3);
    // Load the same value again, then assert reset mid-sequence
    step("same_value", 1'b0, 7'd3, 7'd3);
    step("mid_reset", 1'b1, 7'd77, 7'd0);
    step("after_reset", 1'b0, 7'd85, 7'd85);

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
